// File: rtl/fir_pkg.sv
// Shared defaults, FSM encoding and reset coefficient profile for the FIR tap sequencer.
package fir_pkg;

   localparam int NTAPS_DEF = 8;
   localparam int DW_DEF    = 16;
   localparam int CW_DEF    = 16;
   localparam int AW_DEF    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MAC   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Reset coefficients form a unit impulse on tap 0, making the filter a pass-through.
   localparam int IMPULSE_TAP  = 0;
   localparam int IMPULSE_GAIN = 1;

   function automatic int impulse_coef(input int idx);
      return (idx == IMPULSE_TAP) ? IMPULSE_GAIN : 0;
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate: full-precision product sign-extended into a wrapping accumulator.
module fir_mac #(
   parameter int DW = 16,
   parameter int CW = 16,
   parameter int AW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [AW-1:0] acc
);

   logic signed [DW+CW-1:0] prod_s;
   logic signed [AW-1:0]    prod_ext_s;
   logic signed [AW-1:0]    acc_d;
   logic signed [AW-1:0]    acc_q;

   // Product and next accumulator value; clear takes priority over accumulate.
   always_comb begin
      prod_s     = a * b;
      prod_ext_s = AW'(prod_s);
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + prod_ext_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: pops one sample, runs one MAC per tap, then holds the result until accepted.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int NTAPS = NTAPS_DEF,
   parameter int DW    = DW_DEF,
   parameter int CW    = CW_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic                       clk2,
   input  logic                       reset,
   input  logic                       fifo_empty,
   output logic                       fifo_rd,
   input  logic signed [DW-1:0]       fifo_data,
   input  logic                       cfg_we,
   input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
   input  logic signed [CW-1:0]       cfg_data,
   output logic                       cfg_nack,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [AW-1:0]       out_sum,
   output logic                       busy
);

   localparam int KW = $clog2(NTAPS);

   state_t               state_q, state_d;
   logic [KW-1:0]        wptr_q, wptr_d;
   logic [KW-1:0]        k_q, k_d;
   logic [KW-1:0]        wptr_next_s;
   logic [KW-1:0]        rd_idx_s;
   logic signed [DW-1:0] x_q [NTAPS];
   logic signed [DW-1:0] x_d [NTAPS];
   logic signed [CW-1:0] coef_q [NTAPS];
   logic signed [CW-1:0] coef_d [NTAPS];
   logic                 cfg_nack_q, cfg_nack_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic                 fifo_rd_s;
   logic                 mac_clr_s;
   logic                 mac_en_s;

   // Delay-line addressing: next write slot and the tap read for the current k.
   always_comb begin
      if (wptr_q == KW'(NTAPS - 1)) begin
         wptr_next_s = '0;
      end else begin
         wptr_next_s = wptr_q + KW'(1);
      end
      if (k_q > wptr_q) begin
         rd_idx_s = wptr_q + KW'(NTAPS) - k_q;
      end else begin
         rd_idx_s = wptr_q - k_q;
      end
   end

   // Next-state logic, coefficient writes and datapath controls.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      k_d        = k_q;
      x_d        = x_q;
      coef_d     = coef_q;
      fifo_rd_s  = 1'b0;
      mac_clr_s  = 1'b0;
      mac_en_s   = 1'b0;
      cfg_nack_d = cfg_we && (state_q != IDLE);

      if (cfg_we && (state_q == IDLE)) begin
         coef_d[cfg_addr] = cfg_data;
      end else begin
         coef_d = coef_q;
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_s = 1'b1;
               state_d   = FETCH;
            end else begin
               state_d   = IDLE;
            end
         end
         FETCH: begin
            x_d[wptr_next_s] = fifo_data;
            wptr_d           = wptr_next_s;
            k_d              = '0;
            mac_clr_s        = 1'b1;
            state_d          = MAC;
         end
         MAC: begin
            mac_en_s = 1'b1;
            if (k_q == KW'(NTAPS - 1)) begin
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = MAC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State, pointers, delay line and coefficient registers.
   always_ff @(posedge clk2) begin
      if (reset) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         k_q         <= '0;
         cfg_nack_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i]    <= '0;
            coef_q[i] <= CW'(impulse_coef(i));
         end
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         k_q         <= k_d;
         cfg_nack_q  <= cfg_nack_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         x_q         <= x_d;
         coef_q      <= coef_d;
      end
   end

   fir_mac #(
      .DW (DW),
      .CW (CW),
      .AW (AW)
   ) u_mac (
      .clk   (clk2),
      .reset (reset),
      .clear (mac_clr_s),
      .en    (mac_en_s),
      .a     (x_q[rd_idx_s]),
      .b     (coef_q[k_q]),
      .acc   (out_sum)
   );

   assign fifo_rd   = fifo_rd_s;
   assign cfg_nack  = cfg_nack_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: hand-computed filter outputs, latency, back-pressure and config rules.
module tb_fir_tap_sequencer;

   logic               clk2;
   logic               reset;
   logic               fifo_empty;
   logic               fifo_rd;
   logic signed [15:0] fifo_data;
   logic               cfg_we;
   logic [2:0]         cfg_addr;
   logic signed [15:0] cfg_data;
   logic               cfg_nack;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_sum;
   logic               busy;

   int n_vec = 0;
   int n_err = 0;

   fir_tap_sequencer dut (
      .clk2       (clk2),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_nack   (cfg_nack),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .busy       (busy)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk2);
      reset = 1'b1;
      @(negedge clk2);
      @(negedge clk2);
      reset = 1'b0;
   endtask

   task automatic write_coef(input int addr, input int data);
      @(negedge clk2);
      cfg_we   = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 16'(data);
      @(negedge clk2);
      cfg_we   = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk2);
      while (busy && n < 50) begin
         @(negedge clk2);
         n++;
      end
   endtask

   // Offer one sample; returns in the FETCH cycle with the sample on fifo_data.
   task automatic start_pop(input int s, output bit got);
      int n;
      n = 0;
      @(negedge clk2);
      fifo_empty = 1'b0;
      #1;
      while (!fifo_rd && n < 20) begin
         @(negedge clk2);
         #1;
         n++;
      end
      got = fifo_rd;
      if (!got) begin
         fifo_empty = 1'b1;
      end else begin
         @(posedge clk2);
         #1;
         fifo_empty = 1'b1;
         fifo_data  = 16'(s);
      end
   endtask

   // Counts cycles (fifo_rd cycle = 0) until out_valid rises.
   task automatic wait_out(input int start, output int lat, output int sum);
      lat = start;
      while (!out_valid && lat < 40) begin
         @(posedge clk2);
         #1;
         lat++;
      end
      sum = out_sum;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk2);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_sum !== 32'sd0) begin n_err++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL reset_cfg_nack: got %b expected 0", cfg_nack); end
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
   endtask

   task automatic test_impulse();
      bit got;
      int lat, sum;
      start_pop(1000, got);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL impulse_pop: got %b expected 1", got); end
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL impulse_single_pop: got %b expected 0", fifo_rd); end
      wait_out(1, lat, sum);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL impulse_latency: got %0d expected 10", lat); end
      n_vec++; if (sum !== 1000) begin n_err++; $display("FAIL impulse_sum: got %0d expected 1000", sum); end
   endtask

   task automatic test_back_to_back();
      int samples [6] = '{1000, 2000, 3000, 4000, 5000, 6000};
      int expect_sum [6] = '{1000, 3000, 6000, 10000, 15000, 21000};
      bit got;
      int lat, sum;
      do_reset();
      for (int i = 0; i < 8; i++) write_coef(i, 1);
      n_vec++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL ones_cfg_nack: got %b expected 0", cfg_nack); end
      for (int j = 0; j < 6; j++) begin
         start_pop(samples[j], got);
         wait_out(1, lat, sum);
         n_vec++; if (sum !== expect_sum[j] || lat !== 10) begin
            n_err++; $display("FAIL ones_sum[%0d]: got %0d (lat %0d) expected %0d (lat 10)", j, sum, lat, expect_sum[j]);
         end
      end
   endtask

   task automatic test_wrap();
      int expect_sum [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 2};
      bit got;
      int lat, sum;
      do_reset();
      write_coef(0, 0);
      write_coef(7, 1);
      for (int j = 0; j < 9; j++) begin
         start_pop(j + 1, got);
         wait_out(1, lat, sum);
         n_vec++; if (sum !== expect_sum[j]) begin
            n_err++; $display("FAIL wrap_sum[%0d]: got %0d expected %0d", j, sum, expect_sum[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit got;
      int lat, sum;
      do_reset();
      out_ready = 1'b0;
      start_pop(300, got);
      fifo_empty = 1'b0;
      wait_out(1, lat, sum);
      n_vec++; if (sum !== 300 || lat !== 10) begin n_err++; $display("FAIL bp_first: got %0d (lat %0d) expected 300 (lat 10)", sum, lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk2);
         n_vec++; if (out_valid !== 1'b1 || out_sum !== 32'sd300 || fifo_rd !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d]: got valid=%b sum=%0d rd=%b expected valid=1 sum=300 rd=0", c, out_valid, out_sum, fifo_rd);
         end
      end
      @(negedge clk2);
      out_ready = 1'b1;
      #1;
      n_vec++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL bp_rd_in_handshake: got %b expected 0", fifo_rd); end
      @(posedge clk2);
      #1;
      n_vec++; if (out_valid !== 1'b0 || fifo_rd !== 1'b1) begin
         n_err++; $display("FAIL bp_after_handshake: got valid=%b rd=%b expected valid=0 rd=1", out_valid, fifo_rd);
      end
      @(posedge clk2);
      #1;
      fifo_empty = 1'b1;
      fifo_data  = 16'sd400;
      wait_out(1, lat, sum);
      n_vec++; if (sum !== 400 || lat !== 10) begin n_err++; $display("FAIL bp_second: got %0d (lat %0d) expected 400 (lat 10)", sum, lat); end
   endtask

   task automatic test_cfg_busy();
      bit got;
      int lat, sum;
      do_reset();
      start_pop(50, got);
      @(negedge clk2);
      @(negedge clk2);
      cfg_we   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 16'sd5;
      @(negedge clk2);
      cfg_we   = 1'b0;
      n_vec++; if (cfg_nack !== 1'b1) begin n_err++; $display("FAIL cfg_nack_pulse: got %b expected 1", cfg_nack); end
      @(negedge clk2);
      n_vec++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL cfg_nack_single: got %b expected 0", cfg_nack); end
      wait_out(4, lat, sum);
      n_vec++; if (sum !== 50 || lat !== 10) begin n_err++; $display("FAIL cfg_busy_result: got %0d (lat %0d) expected 50 (lat 10)", sum, lat); end
      wait_idle();
      write_coef(0, 5);
      n_vec++; if (cfg_nack !== 1'b0) begin n_err++; $display("FAIL cfg_idle_nack: got %b expected 0", cfg_nack); end
      start_pop(10, got);
      wait_out(1, lat, sum);
      n_vec++; if (sum !== 50) begin n_err++; $display("FAIL cfg_idle_applied: got %0d expected 50", sum); end
      wait_idle();
      fifo_empty = 1'b0;
      cfg_we     = 1'b1;
      cfg_addr   = 3'd0;
      cfg_data   = 16'sd3;
      #1;
      n_vec++; if (fifo_rd !== 1'b1) begin n_err++; $display("FAIL cfg_same_cycle_pop: got %b expected 1", fifo_rd); end
      @(posedge clk2);
      #1;
      cfg_we     = 1'b0;
      fifo_empty = 1'b1;
      fifo_data  = 16'sd10;
      wait_out(1, lat, sum);
      n_vec++; if (sum !== 30 || lat !== 10) begin n_err++; $display("FAIL cfg_same_cycle_result: got %0d (lat %0d) expected 30 (lat 10)", sum, lat); end
   endtask

   task automatic test_reset_mid_mac();
      bit got;
      int lat, sum;
      do_reset();
      for (int i = 0; i < 8; i++) write_coef(i, 2);
      start_pop(123, got);
      @(negedge clk2);
      @(negedge clk2);
      @(negedge clk2);
      reset = 1'b1;
      @(posedge clk2);
      #1;
      n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL midmac_reset: got valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      @(negedge clk2);
      reset = 1'b0;
      start_pop(7, got);
      wait_out(1, lat, sum);
      n_vec++; if (sum !== 7 || lat !== 10) begin n_err++; $display("FAIL midmac_after: got %0d (lat %0d) expected 7 (lat 10)", sum, lat); end
   endtask

   initial begin
      reset      = 1'b1;
      fifo_empty = 1'b1;
      fifo_data  = 16'sd0;
      cfg_we     = 1'b0;
      cfg_addr   = 3'd0;
      cfg_data   = 16'sd0;
      out_ready  = 1'b1;
      test_reset();
      test_impulse();
      test_back_to_back();
      test_wrap();
      test_backpressure();
      test_cfg_busy();
      test_reset_mid_mac();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
